// File: rtl/matmul_pkg.sv
// Shared FSM encoding, dimension limits and width helpers for matmul_accel.
package matmul_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 8;
  // Row/column/inner counters are sized for the largest legal matrix.
  localparam int IJK_W = $clog2(N_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    if (n < N_MIN) begin
      return 1;
    end else begin
      return $clog2(n * n);
    end
  endfunction

  function automatic int acc_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_accel_if.sv
// Host-side bus of matmul_accel: A/B load port, run control/status, C read port.
interface matmul_accel_if
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 32
);

  localparam int IDX_W = idx_w(N);

  logic              wr_en;
  logic              wr_sel;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [31:0]       cycle_count;

  modport master (
    output wr_en, wr_sel, wr_idx, wr_data, start, rd_idx,
    input  busy, done, ovf, rd_data, cycle_count
  );

  modport slave (
    input  wr_en, wr_sel, wr_idx, wr_data, start, rd_idx,
    output busy, done, ovf, rd_data, cycle_count
  );

endinterface

// File: rtl/matmul_accel_mac_unit.sv
// Combinational multiply-accumulate with truncation check on the incoming accumulator.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = 2,
  parameter int SIGNED = 1,
  parameter int ACC_W  = acc_w(DATA_W, N)
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              trunc_o
);

  localparam int PROD_W = 2 * DATA_W + 2;

  logic signed [DATA_W:0]   a_x_s;
  logic signed [DATA_W:0]   b_x_s;
  logic signed [PROD_W-1:0] prod_s;
  logic [ACC_W-DATA_W:0]    hi_s;

  // One extra operand bit lets a single signed multiplier serve both modes.
  always_comb begin
    if (SIGNED != 0) begin
      a_x_s = {a_i[DATA_W-1], a_i};
      b_x_s = {b_i[DATA_W-1], b_i};
    end else begin
      a_x_s = {1'b0, a_i};
      b_x_s = {1'b0, b_i};
    end
    prod_s = PROD_W'(a_x_s) * PROD_W'(b_x_s);
    acc_o  = acc_i + ACC_W'(prod_s);
  end

  // Loss-free only if everything above the kept field mirrors its extension bit.
  always_comb begin
    hi_s = acc_i[ACC_W-1:DATA_W-1];
    if (SIGNED != 0) begin
      trunc_o = (hi_s != {(ACC_W-DATA_W+1){1'b0}}) &&
                (hi_s != {(ACC_W-DATA_W+1){1'b1}});
    end else begin
      trunc_o = (hi_s[ACC_W-DATA_W:1] != {(ACC_W-DATA_W){1'b0}});
    end
  end

endmodule

// File: rtl/matmul_accel.sv
// N x N integer matrix multiply, one MAC per cycle, with A/B/C flop storage and run-length counter.
module matmul_accel
  import matmul_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  parameter int SIGNED = 1
) (
  input  logic          clk,
  input  logic          reset,
  matmul_accel_if.slave bus
);

  localparam int NN    = N * N;
  localparam int IDX_W = idx_w(N);
  localparam int ACC_W = acc_w(DATA_W, N);
  localparam logic [IJK_W-1:0] LAST = IJK_W'(N - 1);

  state_e            state_q, state_d;
  logic [IJK_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       run_cnt_q, run_cnt_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] a_q [NN];
  logic [DATA_W-1:0] a_d [NN];
  logic [DATA_W-1:0] b_q [NN];
  logic [DATA_W-1:0] b_d [NN];
  logic [DATA_W-1:0] c_q [NN];
  logic [DATA_W-1:0] c_d [NN];

  logic [IDX_W-1:0]  a_idx_s, b_idx_s, c_idx_s;
  logic [ACC_W-1:0]  mac_acc_s;
  logic              trunc_s;
  logic              wr_ok_s;

  mac_unit #(
    .DATA_W (DATA_W),
    .N      (N),
    .SIGNED (SIGNED),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_i     (a_q[a_idx_s]),
    .b_i     (b_q[b_idx_s]),
    .acc_i   (acc_q),
    .acc_o   (mac_acc_s),
    .trunc_o (trunc_s)
  );

  // Flat row-major addresses of the current A, B and C elements.
  always_comb begin
    a_idx_s = IDX_W'(int'(i_q) * N + int'(k_q));
    b_idx_s = IDX_W'(int'(k_q) * N + int'(j_q));
    c_idx_s = IDX_W'(int'(i_q) * N + int'(j_q));
  end

  // Host loads of A/B; a load in the start cycle still lands because busy is low.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    wr_ok_s = bus.wr_en && !busy_q && (int'(bus.wr_idx) < NN);
    if (wr_ok_s) begin
      if (bus.wr_sel) begin
        b_d[bus.wr_idx] = bus.wr_data;
      end else begin
        a_d[bus.wr_idx] = bus.wr_data;
      end
    end else begin
      a_d = a_q;
    end
  end

  // Sequencer: k is the inner loop, j the column, i the row of C.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    acc_d         = acc_q;
    ovf_d         = ovf_q;
    run_cnt_d     = run_cnt_q;
    cycle_count_d = cycle_count_q;
    c_d           = c_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_MAC;
          i_d       = {IJK_W{1'b0}};
          j_d       = {IJK_W{1'b0}};
          k_d       = {IJK_W{1'b0}};
          acc_d     = {ACC_W{1'b0}};
          ovf_d     = 1'b0;
          run_cnt_d = 32'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d     = mac_acc_s;
        run_cnt_d = run_cnt_q + 32'd1;
        if (k_q == LAST) begin
          state_d = ST_WRITE;
        end else begin
          k_d = k_q + IJK_W'(1);
        end
      end
      ST_WRITE: begin
        c_d[c_idx_s] = acc_q[DATA_W-1:0];
        ovf_d        = ovf_q | trunc_s;
        acc_d        = {ACC_W{1'b0}};
        k_d          = {IJK_W{1'b0}};
        run_cnt_d    = run_cnt_q + 32'd1;
        if (j_q != LAST) begin
          j_d     = j_q + IJK_W'(1);
          state_d = ST_MAC;
        end else if (i_q != LAST) begin
          j_d     = {IJK_W{1'b0}};
          i_d     = i_q + IJK_W'(1);
          state_d = ST_MAC;
        end else begin
          // Publish the count now so it is already valid while done is high.
          j_d           = {IJK_W{1'b0}};
          cycle_count_d = run_cnt_q + 32'd1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags follow the next state so they line up with it; read port is one cycle late.
  always_comb begin
    busy_d = (state_d == ST_MAC) || (state_d == ST_WRITE);
    done_d = (state_d == ST_DONE);
    if (int'(bus.rd_idx) < NN) begin
      rd_data_d = c_q[bus.rd_idx];
    end else begin
      rd_data_d = {DATA_W{1'b0}};
    end
  end

  // State, storage and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      i_q           <= {IJK_W{1'b0}};
      j_q           <= {IJK_W{1'b0}};
      k_q           <= {IJK_W{1'b0}};
      acc_q         <= {ACC_W{1'b0}};
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      run_cnt_q     <= 32'd0;
      cycle_count_q <= 32'd0;
      rd_data_q     <= {DATA_W{1'b0}};
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= {DATA_W{1'b0}};
        b_q[n] <= {DATA_W{1'b0}};
        c_q[n] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      ovf_q         <= ovf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      run_cnt_q     <= run_cnt_d;
      cycle_count_q <= cycle_count_d;
      rd_data_q     <= rd_data_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ovf         = ovf_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: doc/matmul_accel.md
# matmul_accel

Parametrised N×N integer matrix-multiply accelerator, the hardware successor to the 2×2 software matmul benchmark run on `cpu`. Host logic loads A and B through a word write port, pulses `start`, and the block computes C = A·B with one multiply-accumulate per cycle, then exposes C through a registered read port. It reports its own run length in cycles for direct comparison against the software benchmark cycle count.

## Interface
- `N`, 2: matrix dimension, legal 2..8.
- `DATA_W`, 32: element width of A, B, C.
- `SIGNED`, 1: 1 = two's-complement operands, 0 = unsigned.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low.
- `wr_en`  input  1  write strobe for A/B storage.
- `wr_sel`  input  1  0 = A, 1 = B.
- `wr_idx`  input  IDX_W = clog2(N*N)  row-major index, row*N+col.
- `wr_data`  input  DATA_W  element value.
- `start`  input  1  begin computation (single-cycle pulse).
- `busy`  output  1  computation in progress.
- `done`  output  1  one-cycle pulse at completion.
- `ovf`  output  1  sticky: some C element truncated with loss.
- `rd_idx`  input  IDX_W  row-major C index.
- `rd_data`  output  DATA_W  C[rd_idx], registered.
- `cycle_count`  output  32  busy cycles of the last completed run.

## Operation
- Storage: A, B, C as N*N×DATA_W flop arrays; all cleared to 0 on reset.
- Writes: accepted only when `busy`=0; `wr_idx` >= N*N ignored; writes while busy dropped silently.
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE: `start`=1 -> MAC; i=j=k=0, acc=0, `ovf` cleared, run counter cleared.
- MAC: acc += A[i][k]*B[k][j]; k==N-1 -> WRITE else k++.
- WRITE: C[i*N+j] <= acc[DATA_W-1:0]; acc=0, k=0; advance j, wrapping to next i; after element (N-1,N-1) -> DONE else -> MAC.
- DONE: `done`=1 for one cycle, `cycle_count` <= run counter -> IDLE.
- Accumulator: ACC_W = 2*DATA_W + clog2(N); products sign- or zero-extended per SIGNED.
- `ovf` set in WRITE when acc is not the sign-extension (SIGNED=1) or zero-extension (SIGNED=0) of its low DATA_W bits; held until next accepted `start`.
- `start` while busy or in DONE ignored.
- Reads: `rd_data` <= C[rd_idx] every cycle; out-of-range index returns 0. Reads during a run return the C array as it stands (already-written elements updated, rest from previous run).

## Timing
- Reset values: `busy`=0, `done`=0, `ovf`=0, `rd_data`=0, `cycle_count`=0, state IDLE.
- `start` sampled at edge 0 -> `busy`=1 from edge 0 through N*N*(N+1) cycles (MAC+WRITE states).
- `done` high the cycle after the last WRITE; `busy`=0 in DONE.
- `cycle_count` = N*N*(N+1) (12 for N=2, 80 for N=4), valid from DONE onward.
- Read latency 1 cycle; C write in WRITE visible to `rd_data` two edges later.
- Write in the same cycle as accepted `start`: write lands (still IDLE), but computation uses the pre-write value only if the element is read before the edge — it is not; element read in MAC sees the new value.
- Reset asserted mid-run: immediate return to IDLE, all arrays and outputs cleared, no `done`.

## Structure
- `matmul_pkg`: FSM state encodings, ACC_W and IDX_W derivation functions, N range constants.
- Sub-module `mac_unit`: combinational signed/unsigned DATA_W×DATA_W multiply with ACC_W accumulate and overflow compare; instantiated once.
- Top holds storage, indices, FSM, counters.

## Test plan
- N=2, SIGNED=1: A={1,2,3,4}, B={5,6,7,8}, start -> C={19,22,43,50}, `done` pulse after 12 busy cycles, `cycle_count`=12, `ovf`=0.
- N=2, SIGNED=1: A={-1,2,0,3}, B={4,-5,6,7} -> C={8,19,18,21}; SIGNED=0 with A all 0xFFFFFFFF, B all 2 -> C all 0xFFFFFFFC, `ovf`=1.
- N=4, A=identity, B=0..15 -> C=0..15, `cycle_count`=80; second `start` clears `ovf` from a prior overflowing run.
- During busy: writes to A[0]=99 and a second `start` -> ignored, results unchanged, single `done`.
- Reset deasserted-then-asserted at cycle 5 of a run -> `busy`=0, `done` never pulses, all `rd_data` reads 0, `cycle_count`=0.
- `wr_idx`/`rd_idx` = N*N with N=3 -> write ignored, `rd_data`=0.
